// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game-flow controller pacing snake steps from VGA frames
//
// Paces snake steps from vsync rising edges, issues one o_step per period,
// waits for step completion / apple respawn, and owns pause, win/lose,
// step-timeout, score and speed-up state.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_restart           synchronous restart (same effect as reset)
//   i_start             first direction press seen, leaves IDLE
//   i_pause             pause button level, rising edge toggles pause
//   i_vsync             VGA vsync, rising edge counts one frame
//   i_step_done         snake finished the requested step
//   i_eat               apple eaten pulse
//   i_apple_ready       apple placed and valid
//   i_failure/i_success collision / board-full pulses
//   o_step              one-cycle step request
//   o_state             IDLE=0 RUN=1 STEP=2 WAIT_APPLE=3 PAUSE=4 FAIL=5 WIN=6
//   o_period            frames per step
//   o_score             apples eaten, saturating
//   o_failure/o_success/o_timeout  sticky result flags

module game_sequencer #(
  parameter int INIT_PERIOD  = 12,
  parameter int MIN_PERIOD   = 3,
  parameter int EATS_PER_LVL = 4,
  parameter int STEP_TIMEOUT = 255,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_restart,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_vsync,
  input  logic               i_step_done,
  input  logic               i_eat,
  input  logic               i_apple_ready,
  input  logic               i_failure,
  input  logic               i_success,
  output logic               o_step,
  output logic [2:0]         o_state,
  output logic [3:0]         o_period,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_failure,
  output logic               o_success,
  output logic               o_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;
  localparam logic [2:0] S_WIN   = 3'd6;

  // Timeout counter counts 0..STEP_TIMEOUT-1; eat counter counts 0..EATS_PER_LVL-1.
  localparam int TO_W = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
  localparam int EC_W = (EATS_PER_LVL > 1) ? $clog2(EATS_PER_LVL) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(STEP_TIMEOUT - 1);
  localparam logic [EC_W-1:0] EC_LAST  = EC_W'(EATS_PER_LVL - 1);
  localparam logic [3:0]      PER_INIT = 4'(INIT_PERIOD);
  localparam logic [3:0]      PER_MIN  = 4'(MIN_PERIOD);

  logic            vsync_q;
  logic            pause_q;
  logic [3:0]      frame_cnt;
  logic [EC_W-1:0] eat_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            pause_pend;
  logic            eat_seen;

  logic vs_rise;
  logic pause_rise;
  logic pend_nx;
  logic live;

  assign vs_rise    = i_vsync & ~vsync_q;
  assign pause_rise = i_pause & ~pause_q;
  // Pending pause including an edge arriving this very cycle.
  assign pend_nx    = pause_pend ^ pause_rise;
  assign live       = (o_state != S_IDLE) && (o_state != S_FAIL) && (o_state != S_WIN);

  always_ff @(posedge clk) begin
    vsync_q <= i_vsync;
    pause_q <= i_pause;
    o_step  <= 1'b0;
    if (!rst_n || i_restart) begin
      o_state    <= S_IDLE;
      o_period   <= PER_INIT;
      o_score    <= '0;
      o_failure  <= 1'b0;
      o_success  <= 1'b0;
      o_timeout  <= 1'b0;
      frame_cnt  <= '0;
      eat_cnt    <= '0;
      to_cnt     <= '0;
      pause_pend <= 1'b0;
      eat_seen   <= 1'b0;
    end else begin
      if (live && i_eat) begin
        if (o_score != {SCORE_W{1'b1}}) o_score <= o_score + SCORE_W'(1);
        if (eat_cnt == EC_LAST) begin
          eat_cnt <= '0;
          if (o_period > PER_MIN) o_period <= o_period - 4'd1;
        end else begin
          eat_cnt <= eat_cnt + EC_W'(1);
        end
      end

      if (live && i_failure) begin
        o_state   <= S_FAIL;
        o_failure <= 1'b1;
      end else if (live && i_success) begin
        o_state   <= S_WIN;
        o_success <= 1'b1;
      end else begin
        case (o_state)
          S_IDLE: begin
            if (i_start) begin
              o_state   <= S_RUN;
              frame_cnt <= '0;
            end
          end
          S_RUN: begin
            if (pause_rise) begin
              o_state <= S_PAUSE;
            end else if (vs_rise) begin
              // >= keeps pacing sane if the period shrank below the running count.
              if (frame_cnt >= o_period - 4'd1) begin
                frame_cnt <= '0;
                o_state   <= S_STEP;
                o_step    <= 1'b1;
                to_cnt    <= '0;
                eat_seen  <= 1'b0;
              end else begin
                frame_cnt <= frame_cnt + 4'd1;
              end
            end
          end
          S_STEP: begin
            if (i_eat) eat_seen <= 1'b1;
            if (i_step_done) begin
              if (eat_seen || i_eat) begin
                o_state    <= S_WAIT;
                pause_pend <= pend_nx;
              end else begin
                o_state    <= pend_nx ? S_PAUSE : S_RUN;
                pause_pend <= 1'b0;
              end
            end else if (to_cnt == TO_LAST) begin
              o_state   <= S_FAIL;
              o_timeout <= 1'b1;
              o_failure <= 1'b1;
            end else begin
              to_cnt     <= to_cnt + TO_W'(1);
              pause_pend <= pend_nx;
            end
          end
          S_WAIT: begin
            if (i_apple_ready) begin
              o_state    <= pend_nx ? S_PAUSE : S_RUN;
              pause_pend <= 1'b0;
            end else begin
              pause_pend <= pend_nx;
            end
          end
          S_PAUSE: begin
            if (pause_rise) o_state <= S_RUN;
          end
          default: o_state <= o_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer

module tb_game_sequencer;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_STEP = 2, ST_WAIT = 3;
  localparam int ST_PAUSE = 4, ST_FAIL = 5, ST_WIN = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_restart = 1'b0, i_start = 1'b0, i_pause = 1'b0, i_vsync = 1'b0;
  logic       i_step_done = 1'b0, i_eat = 1'b0, i_apple_ready = 1'b0;
  logic       i_failure = 1'b0, i_success = 1'b0;
  logic       o_step, o_failure, o_success, o_timeout;
  logic [2:0] o_state;
  logic [3:0] o_period;
  logic [7:0] o_score;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_restart(i_restart), .i_start(i_start),
    .i_pause(i_pause), .i_vsync(i_vsync), .i_step_done(i_step_done),
    .i_eat(i_eat), .i_apple_ready(i_apple_ready), .i_failure(i_failure),
    .i_success(i_success), .o_step(o_step), .o_state(o_state),
    .o_period(o_period), .o_score(o_score), .o_failure(o_failure),
    .o_success(o_success), .o_timeout(o_timeout)
  );

  typedef struct {
    int st; int step; int per; int sc; int f; int s; int t; int dwell;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: game-level quantities only.
  int ms = ST_IDLE;   // expected state
  int mf = 0;         // frames counted toward the next step
  int eats = 0;       // apples eaten since restart
  int pend = 0;       // pause requested while busy
  int mfail = 0, msucc = 0, mtmo = 0;

  function automatic int m_period();
    int p;
    p = 12 - eats / 4;
    return (p < 3) ? 3 : p;
  endfunction

  function automatic int m_score();
    return (eats > 255) ? 255 : eats;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic expect_state(input int st, input int step, input int dwell);
    exp_t e;
    e.st = st; e.step = step; e.per = m_period(); e.sc = m_score();
    e.f = mfail; e.s = msucc; e.t = mtmo; e.dwell = dwell;
    q.push_back(e);
    ms = st;
  endtask

  // Monitor: every state change pops one expected record.
  initial begin : monitor
    exp_t e;
    int   prev;
    int   enter;
    prev = 0;
    enter = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        prev = 0;
      end else if (int'(o_state) != prev) begin
        if (q.size() == 0) begin
          chk("unexpected_transition", int'(o_state), prev);
        end else begin
          e = q.pop_front();
          chk("state", int'(o_state), e.st);
          chk("step_pulse", int'(o_step), e.step);
          chk("period", int'(o_period), e.per);
          chk("score", int'(o_score), e.sc);
          chk("failure_flag", int'(o_failure), e.f);
          chk("success_flag", int'(o_success), e.s);
          chk("timeout_flag", int'(o_timeout), e.t);
          if (e.dwell >= 0) chk("step_dwell", cyc - enter, e.dwell);
        end
        prev = int'(o_state);
        enter = cyc;
      end else begin
        chk("step_quiet", int'(o_step), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    if (ms == ST_RUN) begin
      mf++;
      if (mf >= m_period()) begin
        mf = 0;
        expect_state(ST_STEP, 1, -1);
      end
    end
    i_vsync = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    i_vsync = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic press_pause();
    case (ms)
      ST_RUN:           expect_state(ST_PAUSE, 0, -1);
      ST_PAUSE:         expect_state(ST_RUN, 0, -1);
      ST_STEP, ST_WAIT: pend ^= 1;
      default: ;
    endcase
    i_pause = 1'b1;
    repeat ($urandom_range(1, 2)) tick();
    i_pause = 1'b0;
    tick();
  endtask

  task automatic do_step(input int eat);
    repeat ($urandom_range(1, 5)) tick();
    if (eat != 0) begin
      eats++;
      if ($urandom_range(0, 3) == 0) begin
        expect_state(ST_WAIT, 0, -1);
        i_eat = 1'b1; i_step_done = 1'b1;
        tick();
        i_eat = 1'b0; i_step_done = 1'b0;
      end else begin
        i_eat = 1'b1;
        tick();
        i_eat = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        expect_state(ST_WAIT, 0, -1);
        i_step_done = 1'b1;
        tick();
        i_step_done = 1'b0;
      end
    end else begin
      expect_state((pend != 0) ? ST_PAUSE : ST_RUN, 0, -1);
      pend = 0;
      i_step_done = 1'b1;
      tick();
      i_step_done = 1'b0;
    end
    tick();
  endtask

  task automatic apple();
    repeat ($urandom_range(0, 4)) tick();
    expect_state((pend != 0) ? ST_PAUSE : ST_RUN, 0, -1);
    pend = 0;
    i_apple_ready = 1'b1;
    tick();
    i_apple_ready = 1'b0;
    tick();
  endtask

  task automatic run_to_step();
    for (int n = 0; n < 20 && ms == ST_RUN; n++) frame();
  endtask

  task automatic start_game();
    mf = 0;
    expect_state(ST_RUN, 0, -1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
  endtask

  task automatic restart_game();
    eats = 0; mf = 0; pend = 0; mfail = 0; msucc = 0; mtmo = 0;
    if (ms != ST_IDLE) expect_state(ST_IDLE, 0, -1);
    i_restart = 1'b1;
    tick();
    i_restart = 1'b0;
    tick();
    chk("restart_state", int'(o_state), ST_IDLE);
    chk("restart_period", int'(o_period), 12);
    chk("restart_score", int'(o_score), 0);
    chk("restart_flags", int'({o_failure, o_success, o_timeout}), 0);
  endtask

  task automatic play_step(input int eat, input int pause_in_step);
    run_to_step();
    if (pause_in_step != 0) press_pause();
    do_step(eat);
    if (ms == ST_WAIT) apple();
    if (ms == ST_PAUSE) begin
      repeat ($urandom_range(0, 3)) frame();
      press_pause();
    end
  endtask

  initial begin : stimulus
    repeat (3) tick();
    chk("reset_state", int'(o_state), ST_IDLE);
    chk("reset_period", int'(o_period), 12);
    chk("reset_score", int'(o_score), 0);
    chk("reset_step", int'(o_step), 0);
    chk("reset_flags", int'({o_failure, o_success, o_timeout}), 0);
    rst_n = 1'b1;
    tick();

    // Pause edges in IDLE are ignored; then twelve frames make one step.
    press_pause();
    start_game();
    for (int i = 0; i < 12; i++) frame();
    chk("first_step_state", int'(o_state), ST_STEP);
    do_step(0);
    chk("after_done_state", int'(o_state), ST_RUN);

    // Eat during a step, apple not yet ready.
    run_to_step();
    do_step(1);
    chk("wait_apple_state", int'(o_state), ST_WAIT);
    chk("first_eat_score", int'(o_score), 1);
    apple();

    // Pause in RUN after five frames, long freeze, resume needs seven more.
    for (int i = 0; i < 5; i++) frame();
    press_pause();
    for (int i = 0; i < 50; i++) frame();
    press_pause();
    for (int i = 0; i < 6; i++) frame();
    chk("resume_no_step_yet", int'(o_state), ST_RUN);
    frame();
    chk("resume_step_state", int'(o_state), ST_STEP);
    do_step(0);

    // Pause during STEP takes effect after step_done; a double press cancels.
    play_step(0, 1);
    run_to_step();
    press_pause();
    press_pause();
    do_step(0);
    chk("double_pause_run", int'(o_state), ST_RUN);

    // Speed-up to the floor period.
    while (eats < 40) begin
      play_step(1, ($urandom_range(0, 5) == 0) ? 1 : 0);
      if (eats == 4) chk("period_lvl1", int'(o_period), 11);
      if ($urandom_range(0, 7) == 0) begin
        press_pause();
        repeat ($urandom_range(1, 3)) frame();
        press_pause();
      end
    end
    chk("period_floor", int'(o_period), 3);
    chk("score_40", int'(o_score), 40);

    // Restart mid-STEP: no step reissue.
    run_to_step();
    restart_game();
    repeat (10) tick();

    // Step timeout.
    start_game();
    run_to_step();
    mfail = 1; mtmo = 1;
    expect_state(ST_FAIL, 0, 255);
    repeat (270) tick();
    for (int i = 0; i < 15; i++) frame();
    chk("timeout_state", int'(o_state), ST_FAIL);
    chk("timeout_flag_hold", int'(o_timeout), 1);

    // Simultaneous failure and success: failure wins.
    restart_game();
    start_game();
    run_to_step();
    mfail = 1;
    expect_state(ST_FAIL, 0, -1);
    i_failure = 1'b1; i_success = 1'b1;
    tick();
    i_failure = 1'b0; i_success = 1'b0;
    for (int i = 0; i < 13; i++) frame();

    // Win from RUN, absorbing.
    restart_game();
    start_game();
    for (int i = 0; i < 3; i++) frame();
    msucc = 1;
    expect_state(ST_WIN, 0, -1);
    i_success = 1'b1;
    tick();
    i_success = 1'b0;
    press_pause();
    for (int i = 0; i < 13; i++) frame();

    // Random play.
    restart_game();
    start_game();
    for (int i = 0; i < 12; i++)
      play_step(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    chk("random_score", int'(o_score), m_score());
    chk("random_period", int'(o_period), m_period());

    repeat (5) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
